// File: rtl/core_decode_stage.sv
// core_decode_stage: registered RV32I/RV64I (+ optional M) decode stage.
// A combinational decoder feeds a main output register backed by one skid
// register, so fetch sees a ready that comes straight from a flop.
//
// Buffer occupancy:
//   state        | meaning
//   empty        | main and skid invalid, out_valid_o = 0, in_ready_o = 1
//   main         | main holds a beat, skid empty, in_ready_o = 1
//   main+skid    | both hold beats, in_ready_o = 0 until main drains
module core_decode_stage #(
  parameter int unsigned XLEN = 32,
  parameter bit          EN_M = 1'b0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     in_inst_i,
  input  logic [XLEN-1:0] in_pc_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] out_pc_o,
  output logic [5:0]      out_op_o,
  output logic [4:0]      out_rd_o,
  output logic [4:0]      out_rs1_o,
  output logic [4:0]      out_rs2_o,
  output logic [XLEN-1:0] out_imm_o,
  output logic            out_illegal_o
);

  localparam logic [5:0] OP_ILLEGAL = 6'd0;
  localparam logic [5:0] OP_LUI     = 6'd1;
  localparam logic [5:0] OP_AUIPC   = 6'd2;
  localparam logic [5:0] OP_JAL     = 6'd3;
  localparam logic [5:0] OP_JALR    = 6'd4;
  localparam logic [5:0] OP_BEQ     = 6'd5;
  localparam logic [5:0] OP_BNE     = 6'd6;
  localparam logic [5:0] OP_BLT     = 6'd7;
  localparam logic [5:0] OP_BGE     = 6'd8;
  localparam logic [5:0] OP_BLTU    = 6'd9;
  localparam logic [5:0] OP_BGEU    = 6'd10;
  localparam logic [5:0] OP_LB      = 6'd11;
  localparam logic [5:0] OP_LH      = 6'd12;
  localparam logic [5:0] OP_LW      = 6'd13;
  localparam logic [5:0] OP_LBU     = 6'd14;
  localparam logic [5:0] OP_LHU     = 6'd15;
  localparam logic [5:0] OP_SB      = 6'd16;
  localparam logic [5:0] OP_SH      = 6'd17;
  localparam logic [5:0] OP_SW      = 6'd18;
  localparam logic [5:0] OP_ADDI    = 6'd19;
  localparam logic [5:0] OP_SLTI    = 6'd20;
  localparam logic [5:0] OP_SLTIU   = 6'd21;
  localparam logic [5:0] OP_XORI    = 6'd22;
  localparam logic [5:0] OP_ORI     = 6'd23;
  localparam logic [5:0] OP_ANDI    = 6'd24;
  localparam logic [5:0] OP_SLLI    = 6'd25;
  localparam logic [5:0] OP_SRLI    = 6'd26;
  localparam logic [5:0] OP_SRAI    = 6'd27;
  localparam logic [5:0] OP_ADD     = 6'd28;
  localparam logic [5:0] OP_SUB     = 6'd29;
  localparam logic [5:0] OP_SLL     = 6'd30;
  localparam logic [5:0] OP_SLT     = 6'd31;
  localparam logic [5:0] OP_SLTU    = 6'd32;
  localparam logic [5:0] OP_XOR     = 6'd33;
  localparam logic [5:0] OP_SRL     = 6'd34;
  localparam logic [5:0] OP_SRA     = 6'd35;
  localparam logic [5:0] OP_OR      = 6'd36;
  localparam logic [5:0] OP_AND     = 6'd37;
  localparam logic [5:0] OP_MUL     = 6'd38;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [5:0]      op;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    logic            illegal;
  } entry_t;

  // All RV immediates are 32-bit quantities sign-extended from bit 31.
  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'({{32{v[31]}}, v});
  endfunction

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        shamt_hi_ok;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = in_inst_i[6:0];
  assign funct3 = in_inst_i[14:12];
  assign funct7 = in_inst_i[31:25];
  // inst[25] is shamt[5]; only meaningful on RV64.
  assign shamt_hi_ok = (XLEN == 64) || !in_inst_i[25];

  assign imm_i = {{20{in_inst_i[31]}}, in_inst_i[31:20]};
  assign imm_s = {{20{in_inst_i[31]}}, in_inst_i[31:25], in_inst_i[11:7]};
  assign imm_b = {{19{in_inst_i[31]}}, in_inst_i[31], in_inst_i[7],
                  in_inst_i[30:25], in_inst_i[11:8], 1'b0};
  assign imm_u = {in_inst_i[31:12], 12'b0};
  assign imm_j = {{11{in_inst_i[31]}}, in_inst_i[31], in_inst_i[19:12],
                  in_inst_i[20], in_inst_i[30:21], 1'b0};

  logic [5:0]  dec_op;
  logic        dec_illegal;
  logic        use_rd, use_rs1, use_rs2;
  logic [31:0] dec_imm32;
  entry_t      dec_entry;

  // Instruction decode: pick operation ID, used register fields and immediate.
  always_comb begin
    dec_op    = OP_ILLEGAL;
    use_rd    = 1'b0;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    dec_imm32 = '0;
    case (opcode)
      OPC_LUI: begin
        dec_op = OP_LUI;   use_rd = 1'b1; dec_imm32 = imm_u;
      end
      OPC_AUIPC: begin
        dec_op = OP_AUIPC; use_rd = 1'b1; dec_imm32 = imm_u;
      end
      OPC_JAL: begin
        dec_op = OP_JAL;   use_rd = 1'b1; dec_imm32 = imm_j;
      end
      OPC_JALR: begin
        use_rd = 1'b1; use_rs1 = 1'b1; dec_imm32 = imm_i;
        if (funct3 == 3'b000) dec_op = OP_JALR;
      end
      OPC_BRANCH: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; dec_imm32 = imm_b;
        case (funct3)
          3'b000:  dec_op = OP_BEQ;
          3'b001:  dec_op = OP_BNE;
          3'b100:  dec_op = OP_BLT;
          3'b101:  dec_op = OP_BGE;
          3'b110:  dec_op = OP_BLTU;
          3'b111:  dec_op = OP_BGEU;
          default: dec_op = OP_ILLEGAL;
        endcase
      end
      OPC_LOAD: begin
        use_rd = 1'b1; use_rs1 = 1'b1; dec_imm32 = imm_i;
        case (funct3)
          3'b000:  dec_op = OP_LB;
          3'b001:  dec_op = OP_LH;
          3'b010:  dec_op = OP_LW;
          3'b100:  dec_op = OP_LBU;
          3'b101:  dec_op = OP_LHU;
          default: dec_op = OP_ILLEGAL;
        endcase
      end
      OPC_STORE: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; dec_imm32 = imm_s;
        case (funct3)
          3'b000:  dec_op = OP_SB;
          3'b001:  dec_op = OP_SH;
          3'b010:  dec_op = OP_SW;
          default: dec_op = OP_ILLEGAL;
        endcase
      end
      OPC_OPIMM: begin
        use_rd = 1'b1; use_rs1 = 1'b1; dec_imm32 = imm_i;
        case (funct3)
          3'b000: dec_op = OP_ADDI;
          3'b010: dec_op = OP_SLTI;
          3'b011: dec_op = OP_SLTIU;
          3'b100: dec_op = OP_XORI;
          3'b110: dec_op = OP_ORI;
          3'b111: dec_op = OP_ANDI;
          3'b001: begin
            if (in_inst_i[31:26] == 6'b000000 && shamt_hi_ok) dec_op = OP_SLLI;
          end
          default: begin
            if (in_inst_i[31:26] == 6'b000000 && shamt_hi_ok)      dec_op = OP_SRLI;
            else if (in_inst_i[31:26] == 6'b010000 && shamt_hi_ok) dec_op = OP_SRAI;
          end
        endcase
      end
      OPC_OP: begin
        use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
        case (funct7)
          7'b0000000: begin
            case (funct3)
              3'b000:  dec_op = OP_ADD;
              3'b001:  dec_op = OP_SLL;
              3'b010:  dec_op = OP_SLT;
              3'b011:  dec_op = OP_SLTU;
              3'b100:  dec_op = OP_XOR;
              3'b101:  dec_op = OP_SRL;
              3'b110:  dec_op = OP_OR;
              default: dec_op = OP_AND;
            endcase
          end
          7'b0100000: begin
            if (funct3 == 3'b000)      dec_op = OP_SUB;
            else if (funct3 == 3'b101) dec_op = OP_SRA;
          end
          7'b0000001: begin
            if (EN_M) dec_op = OP_MUL + {3'b000, funct3};
          end
          default: dec_op = OP_ILLEGAL;
        endcase
      end
      default: dec_op = OP_ILLEGAL;
    endcase
    dec_illegal = (dec_op == OP_ILLEGAL);
  end

  // Pack the decoded beat; illegal beats carry only the PC and the flag.
  always_comb begin
    dec_entry         = '0;
    dec_entry.pc      = in_pc_i;
    dec_entry.op      = dec_op;
    dec_entry.illegal = dec_illegal;
    if (!dec_illegal) begin
      dec_entry.rd  = use_rd  ? in_inst_i[11:7]  : 5'd0;
      dec_entry.rs1 = use_rs1 ? in_inst_i[19:15] : 5'd0;
      dec_entry.rs2 = use_rs2 ? in_inst_i[24:20] : 5'd0;
      dec_entry.imm = sext32(dec_imm32);
    end
  end

  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  logic   main_valid_q, main_valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   in_ready_q;
  logic   accept;

  assign accept = in_valid_i && in_ready_q;

  // Buffer control: flush wins, then skid drain, then accept into main or skid.
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush_i) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      // Skid full implies main full and ready low, so no accept here.
      if (out_ready_i) begin
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (!main_valid_q || out_ready_i) begin
        main_d       = dec_entry;
        main_valid_d = 1'b1;
      end else begin
        skid_d       = dec_entry;
        skid_valid_d = 1'b1;
      end
    end else if (out_ready_i) begin
      main_valid_d = 1'b0;
    end
  end

  // State registers; ready is kept in its own flop so fetch sees no logic.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= !skid_valid_d;
    end
  end

  assign in_ready_o    = in_ready_q;
  assign out_valid_o   = main_valid_q;
  assign out_pc_o      = main_q.pc;
  assign out_op_o      = main_q.op;
  assign out_rd_o      = main_q.rd;
  assign out_rs1_o     = main_q.rs1;
  assign out_rs2_o     = main_q.rs2;
  assign out_imm_o     = main_q.imm;
  assign out_illegal_o = main_q.illegal;

endmodule

// File: tb/tb_core_decode_stage.sv
// Directed bench: RV32 without M and RV64 with M side by side on shared inputs.
module tb_core_decode_stage;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] inst;
  logic [63:0] pc;

  logic        a_in_ready, a_out_valid, a_ill;
  logic [31:0] a_pc, a_imm;
  logic [5:0]  a_op;
  logic [4:0]  a_rd, a_rs1, a_rs2;

  logic        b_in_ready, b_out_valid, b_ill;
  logic [63:0] b_pc, b_imm;
  logic [5:0]  b_op;
  logic [4:0]  b_rd, b_rs1, b_rs2;

  int n_vec = 0;
  int n_err = 0;

  core_decode_stage #(.XLEN(32), .EN_M(1'b0)) dut32 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(a_in_ready),
    .in_inst_i(inst), .in_pc_i(pc[31:0]),
    .out_valid_o(a_out_valid), .out_ready_i(out_ready),
    .out_pc_o(a_pc), .out_op_o(a_op), .out_rd_o(a_rd),
    .out_rs1_o(a_rs1), .out_rs2_o(a_rs2), .out_imm_o(a_imm),
    .out_illegal_o(a_ill)
  );

  core_decode_stage #(.XLEN(64), .EN_M(1'b1)) dut64 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(b_in_ready),
    .in_inst_i(inst), .in_pc_i(pc),
    .out_valid_o(b_out_valid), .out_ready_i(out_ready),
    .out_pc_o(b_pc), .out_op_o(b_op), .out_rd_o(b_rd),
    .out_rs1_o(b_rs1), .out_rs2_o(b_rs2), .out_imm_o(b_imm),
    .out_illegal_o(b_ill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    bit          ok32;
    bit          ok64;
    logic [5:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [63:0] imm;
  } vec_t;

  task automatic test_reset();
    n_vec++; if (a_out_valid !== 1'b0 || b_out_valid !== 1'b0) begin n_err++;
      $display("FAIL reset_valid got %b/%b want 0/0", a_out_valid, b_out_valid); end
    n_vec++; if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin n_err++;
      $display("FAIL reset_ready got %b/%b want 1/1", a_in_ready, b_in_ready); end
    n_vec++; if ({a_op, a_ill, a_rd, a_rs1, a_rs2} !== 22'd0) begin n_err++;
      $display("FAIL reset_fields32 got op=%0d ill=%b rd=%0d rs1=%0d rs2=%0d want 0",
               a_op, a_ill, a_rd, a_rs1, a_rs2); end
    n_vec++; if (a_imm !== 32'd0 || a_pc !== 32'd0 || b_imm !== 64'd0 || b_pc !== 64'd0) begin
      n_err++; $display("FAIL reset_data got imm=%h/%h pc=%h/%h want 0", a_imm, b_imm, a_pc, b_pc); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    n_vec++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin n_err++;
      $display("FAIL post_reset_idle got valid=%b ready=%b want 0/1", a_out_valid, a_in_ready); end
  endtask

  task automatic test_decode_back_to_back();
    vec_t v[9];
    logic [53:0] exp32, got32;
    logic [85:0] exp64, got64;
    v[0] = '{32'hFAAAF0B7, 1'b1, 1'b1, 6'd1,  5'd1,  5'd0, 5'd0, 64'hFFFF_FFFF_FAAA_F000};
    v[1] = '{32'h7FE991EF, 1'b1, 1'b1, 6'd3,  5'd3,  5'd0, 5'd0, 64'h0000_0000_0009_97FE};
    v[2] = '{32'h4013DAB3, 1'b1, 1'b1, 6'd35, 5'd21, 5'd7, 5'd1, 64'h0};
    v[3] = '{32'h02208033, 1'b0, 1'b1, 6'd38, 5'd0,  5'd1, 5'd2, 64'h0};
    v[4] = '{32'h02009093, 1'b0, 1'b1, 6'd25, 5'd1,  5'd1, 5'd0, 64'h20};
    v[5] = '{32'hFE20AE23, 1'b1, 1'b1, 6'd18, 5'd0,  5'd1, 5'd2, 64'hFFFF_FFFF_FFFF_FFFC};
    v[6] = '{32'h00208863, 1'b1, 1'b1, 6'd5,  5'd0,  5'd1, 5'd2, 64'h10};
    v[7] = '{32'h00832283, 1'b1, 1'b1, 6'd13, 5'd5,  5'd6, 5'd0, 64'h8};
    v[8] = '{32'h00000000, 1'b0, 1'b0, 6'd0,  5'd0,  5'd0, 5'd0, 64'h0};
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1;
      inst     = v[i].inst;
      pc       = 64'h8000_0000_0000_1000 + 64'(4 * i);
      @(posedge clk); #1;
      exp32 = v[i].ok32 ? {v[i].op, 1'b0, v[i].rd, v[i].rs1, v[i].rs2, v[i].imm[31:0]}
                        : {6'd0, 1'b1, 15'd0, 32'd0};
      exp64 = v[i].ok64 ? {v[i].op, 1'b0, v[i].rd, v[i].rs1, v[i].rs2, v[i].imm}
                        : {6'd0, 1'b1, 15'd0, 64'd0};
      got32 = {a_op, a_ill, a_rd, a_rs1, a_rs2, a_imm};
      got64 = {b_op, b_ill, b_rd, b_rs1, b_rs2, b_imm};
      n_vec++; if (got32 !== exp32) begin n_err++;
        $display("FAIL decode32[%0d] inst=%h got %h want %h", i, v[i].inst, got32, exp32); end
      n_vec++; if (got64 !== exp64) begin n_err++;
        $display("FAIL decode64[%0d] inst=%h got %h want %h", i, v[i].inst, got64, exp64); end
      n_vec++; if (a_out_valid !== 1'b1 || b_out_valid !== 1'b1 ||
                   a_pc !== pc[31:0] || b_pc !== pc) begin n_err++;
        $display("FAIL beat[%0d] got valid=%b/%b pc=%h/%h want 1/1 pc=%h",
                 i, a_out_valid, b_out_valid, a_pc, b_pc, pc); end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    n_vec++; if (a_out_valid !== 1'b0 || b_out_valid !== 1'b0) begin n_err++;
      $display("FAIL drain got valid=%b/%b want 0/0", a_out_valid, b_out_valid); end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_pc[3];
    exp_pc[0] = 32'h0; exp_pc[1] = 32'h4; exp_pc[2] = 32'h8;
    out_ready = 1'b0;
    inst      = 32'h00100093;
    in_valid  = 1'b1; pc = 64'h0;
    @(posedge clk); #1;
    n_vec++; if (a_out_valid !== 1'b1 || a_pc !== 32'h0 || a_in_ready !== 1'b1) begin n_err++;
      $display("FAIL bp_main got valid=%b pc=%h ready=%b want 1 0 1", a_out_valid, a_pc, a_in_ready); end
    pc = 64'h4;
    @(posedge clk); #1;
    n_vec++; if (a_pc !== 32'h0 || a_in_ready !== 1'b0 || b_in_ready !== 1'b0) begin n_err++;
      $display("FAIL bp_skid got pc=%h ready=%b/%b want 0 0/0", a_pc, a_in_ready, b_in_ready); end
    pc = 64'h8;
    @(posedge clk); #1;
    n_vec++; if (a_out_valid !== 1'b1 || a_pc !== 32'h0 || a_in_ready !== 1'b0) begin n_err++;
      $display("FAIL bp_stall got valid=%b pc=%h ready=%b want 1 0 0", a_out_valid, a_pc, a_in_ready); end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n_vec++; if (a_out_valid !== 1'b1 || a_pc !== exp_pc[k] || b_pc !== {32'd0, exp_pc[k]}) begin
        n_err++; $display("FAIL bp_order[%0d] got valid=%b pc=%h/%h want 1 pc=%h",
                          k, a_out_valid, a_pc, b_pc, exp_pc[k]); end
      @(posedge clk); #1;
      if (k == 1) in_valid = 1'b0;
    end
    n_vec++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin n_err++;
      $display("FAIL bp_empty got valid=%b ready=%b want 0 1", a_out_valid, a_in_ready); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    inst      = 32'h00100093;
    in_valid  = 1'b1; pc = 64'h10;
    @(posedge clk); #1;
    pc = 64'h14;
    @(posedge clk); #1;
    n_vec++; if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1) begin n_err++;
      $display("FAIL flush_setup got ready=%b valid=%b want 0 1", a_in_ready, a_out_valid); end
    pc = 64'h18; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n_vec++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 ||
                 b_out_valid !== 1'b0 || b_in_ready !== 1'b1) begin n_err++;
      $display("FAIL flush_full got valid=%b/%b ready=%b/%b want 0/0 1/1",
               a_out_valid, b_out_valid, a_in_ready, b_in_ready); end
    n_vec++; if (a_pc !== 32'h10) begin n_err++;
      $display("FAIL flush_hold got pc=%h want 00000010", a_pc); end
    out_ready = 1'b1; pc = 64'h1C;
    @(posedge clk); #1;
    n_vec++; if (a_out_valid !== 1'b1 || a_pc !== 32'h1C) begin n_err++;
      $display("FAIL flush_resume got valid=%b pc=%h want 1 0000001c", a_out_valid, a_pc); end
    // A flush with ready high still drops the beat offered in that cycle.
    pc = 64'h20; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    n_vec++; if (a_out_valid !== 1'b0 || a_pc !== 32'h1C) begin n_err++;
      $display("FAIL flush_drop got valid=%b pc=%h want 0 0000001c", a_out_valid, a_pc); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    inst      = 32'hFAAAF0B7;
    pc        = 64'h40;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_vec++; if (a_out_valid !== 1'b1 || a_imm !== 32'hFAAAF000) begin n_err++;
      $display("FAIL arst_pre got valid=%b imm=%h want 1 faaaf000", a_out_valid, a_imm); end
    #2 rst = 1'b1;
    #1;
    n_vec++; if (a_out_valid !== 1'b0 || a_imm !== 32'd0 || b_out_valid !== 1'b0 ||
                 b_imm !== 64'd0) begin n_err++;
      $display("FAIL arst_clear got valid=%b/%b imm=%h/%h want 0/0 0",
               a_out_valid, b_out_valid, a_imm, b_imm); end
    n_vec++; if (a_op !== 6'd0 || a_pc !== 32'd0 || a_in_ready !== 1'b1) begin n_err++;
      $display("FAIL arst_fields got op=%0d pc=%h ready=%b want 0 0 1", a_op, a_pc, a_in_ready); end
    #2 rst = 1'b0;
    out_ready = 1'b1;
    inst      = 32'h7FE991EF;
    pc        = 64'h44;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_vec++; if (a_out_valid !== 1'b1 || a_op !== 6'd3 || a_pc !== 32'h44) begin n_err++;
      $display("FAIL arst_resume got valid=%b op=%0d pc=%h want 1 3 00000044",
               a_out_valid, a_op, a_pc); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    inst = 32'd0; pc = 64'd0;
    #1 rst = 1'b1;
    #2;
    test_reset();
    test_decode_back_to_back();
    test_backpressure();
    test_flush();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
